// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction-memory request bus and decode valid/ready channel.
interface fetch_sequencer_if;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        imem_miss;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    modport master (output imem_en, imem_addr, dec_valid, dec_inst, dec_pc,
                    input  imem_data, imem_miss, dec_ready);
    modport slave  (input  imem_en, imem_addr, dec_valid, dec_inst, dec_pc,
                    output imem_data, imem_miss, dec_ready);
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, fetches from instruction memory through miss wait-states,
// and hands instruction/PC pairs to decode with branch redirect and backpressure handling.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          MISS_CNT_W = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_br_taken,
    input  logic [31:0]           i_br_target,
    output logic                  o_misalign,
    output logic [MISS_CNT_W-1:0] o_miss_count,
    fetch_sequencer_if.master     bus
);
    typedef enum logic [1:0] {IDLE, FETCH, MISS, HOLD} state_t;
    state_t                r_state;
    logic [31:0]           r_pc;
    logic [31:0]           r_inst;
    logic [31:0]           r_dpc;
    logic                  r_en;
    logic                  r_valid;
    logic                  r_misalign;
    logic [MISS_CNT_W-1:0] r_miss_cnt;
    logic                  w_slot_free;
    logic                  w_miss_cyc;
    assign w_slot_free    = !r_valid || bus.dec_ready;
    assign w_miss_cyc     = r_en && bus.imem_miss;
    assign bus.imem_en    = r_en;
    assign bus.imem_addr  = r_pc;
    assign bus.dec_valid  = r_valid;
    assign bus.dec_inst   = r_inst;
    assign bus.dec_pc     = r_dpc;
    assign o_misalign     = r_misalign;
    assign o_miss_count   = r_miss_cnt;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_pc       <= {RESET_PC[31:2], 2'b00};
            r_inst     <= '0;
            r_dpc      <= '0;
            r_en       <= 1'b0;
            r_valid    <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            // a redirect overrides any miss, hold or same-cycle capture
            if (r_state != IDLE && i_br_taken) begin
                r_state    <= FETCH;
                r_pc       <= {i_br_target[31:2], 2'b00};
                r_en       <= 1'b1;
                r_valid    <= 1'b0;
                r_misalign <= |i_br_target[1:0];
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= FETCH;
                        r_en    <= 1'b1;
                    end
                    FETCH, MISS: begin
                        if (bus.imem_miss) begin
                            r_state <= MISS;
                            r_valid <= r_valid && !bus.dec_ready;
                        end else if (w_slot_free) begin
                            r_state <= FETCH;
                            r_inst  <= bus.imem_data;
                            r_dpc   <= r_pc;
                            r_valid <= 1'b1;
                            r_pc    <= r_pc + 32'd4;
                        end else begin
                            r_state <= HOLD;
                            r_en    <= 1'b0;
                        end
                    end
                    HOLD: begin
                        if (bus.dec_ready) begin
                            r_state <= FETCH;
                            r_en    <= 1'b1;
                            r_valid <= 1'b0;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_miss_cnt <= '0;
        else if (w_miss_cyc && !(&r_miss_cnt))
            r_miss_cnt <= r_miss_cnt + MISS_CNT_W'(1);
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vectors for fetch, miss, backpressure, branch, wrap, reset and saturation.
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        br = 1'b0;
    logic        br2 = 1'b0;
    logic [31:0] tgt = '0;
    logic        misalign;
    logic        misalign2;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
    int          n_chk = 0;
    int          n_err = 0;
    fetch_sequencer_if bif();
    fetch_sequencer_if bif2();
    always #5 clk = ~clk;
    // ROM model: instruction word is the bitwise inverse of its address
    assign bif.imem_data  = ~bif.imem_addr;
    assign bif2.imem_data = ~bif2.imem_addr;
    fetch_sequencer #(.RESET_PC(32'h0), .MISS_CNT_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_br_taken(br), .i_br_target(tgt),
        .o_misalign(misalign), .o_miss_count(cnt), .bus(bif.master));
    fetch_sequencer #(.RESET_PC(32'h43), .MISS_CNT_W(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_br_taken(br2), .i_br_target(32'h0),
        .o_misalign(misalign2), .o_miss_count(cnt2), .bus(bif2.master));
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk_reset(input string tag);
        chk({tag, "_en"},    32'(bif.imem_en), 32'h0);
        chk({tag, "_addr"},  bif.imem_addr, 32'h0);
        chk({tag, "_valid"}, 32'(bif.dec_valid), 32'h0);
        chk({tag, "_inst"},  bif.dec_inst, 32'h0);
        chk({tag, "_pc"},    bif.dec_pc, 32'h0);
        chk({tag, "_mis"},   32'(misalign), 32'h0);
        chk({tag, "_cnt"},   32'(cnt), 32'h0);
    endtask
    initial begin
        bif.imem_miss  = 1'b0;
        bif.dec_ready  = 1'b1;
        bif2.imem_miss = 1'b0;
        bif2.dec_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk_reset("rst");
        chk("rst2_addr", bif2.imem_addr, 32'h40);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("idle_en", 32'(bif.imem_en), 32'h1);
        chk("idle_valid", 32'(bif.dec_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("seq_pc", bif.dec_pc, 32'(i * 4));
            chk("seq_inst", bif.dec_inst, ~32'(i * 4));
            chk("seq_valid", 32'(bif.dec_valid), 32'h1);
        end
        chk("miss_addr0", bif.imem_addr, 32'h10);
        bif.imem_miss = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("miss_addr", bif.imem_addr, 32'h10);
            chk("miss_valid", 32'(bif.dec_valid), 32'h0);
            chk("miss_cnt", 32'(cnt), 32'(i));
        end
        bif.imem_miss = 1'b0;
        step();
        chk("miss_pc", bif.dec_pc, 32'h10);
        chk("miss_done_valid", 32'(bif.dec_valid), 32'h1);
        chk("miss_cnt_final", 32'(cnt), 32'h3);
        bif.dec_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("hold_en", 32'(bif.imem_en), 32'h0);
            chk("hold_pc", bif.dec_pc, 32'h10);
            chk("hold_inst", bif.dec_inst, ~32'h10);
            chk("hold_valid", 32'(bif.dec_valid), 32'h1);
        end
        bif.dec_ready = 1'b1;
        step();
        chk("unhold_valid", 32'(bif.dec_valid), 32'h0);
        chk("unhold_addr", bif.imem_addr, 32'h14);
        step();
        chk("unhold_pc", bif.dec_pc, 32'h14);
        chk("unhold_valid2", 32'(bif.dec_valid), 32'h1);
        bif.imem_miss = 1'b1;
        step();
        chk("brm_addr", bif.imem_addr, 32'h18);
        chk("brm_valid", 32'(bif.dec_valid), 32'h0);
        br  = 1'b1;
        tgt = 32'h100;
        step();
        br = 1'b0;
        bif.imem_miss = 1'b0;
        chk("brm_tgt", bif.imem_addr, 32'h100);
        chk("brm_flush", 32'(bif.dec_valid), 32'h0);
        chk("brm_mis", 32'(misalign), 32'h0);
        chk("brm_cnt", 32'(cnt), 32'h5);
        step();
        chk("brm_pc", bif.dec_pc, 32'h100);
        chk("brm_inst", bif.dec_inst, ~32'h100);
        br  = 1'b1;
        tgt = 32'hFFFF_FFFE;
        step();
        br = 1'b0;
        chk("mis_pulse", 32'(misalign), 32'h1);
        chk("mis_discard", 32'(bif.dec_valid), 32'h0);
        chk("mis_addr", bif.imem_addr, 32'hFFFF_FFFC);
        step();
        chk("mis_clear", 32'(misalign), 32'h0);
        chk("wrap_pc0", bif.dec_pc, 32'hFFFF_FFFC);
        chk("wrap_addr", bif.imem_addr, 32'h0);
        step();
        chk("wrap_pc1", bif.dec_pc, 32'h0);
        bif.dec_ready = 1'b0;
        step();
        chk("pre_rst_en", 32'(bif.imem_en), 32'h0);
        #3 rst_n = 1'b0;
        #1;
        chk_reset("arst");
        @(negedge clk);
        br  = 1'b1;
        tgt = 32'h200;
        bif.dec_ready = 1'b1;
        rst_n = 1'b1;
        step();
        br = 1'b0;
        chk("idle_br_addr", bif.imem_addr, 32'h0);
        chk("idle_br_mis", 32'(misalign), 32'h0);
        chk("idle_br_en", 32'(bif.imem_en), 32'h1);
        step();
        chk("idle_br_pc", bif.dec_pc, 32'h0);
        bif2.imem_miss = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("sat_cnt", 32'(cnt2), (i < 3) ? 32'(i) : 32'h3);
        end
        chk("sat_addr", bif2.imem_addr, 32'h44);
        chk("sat_mis", 32'(misalign2), 32'h0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Requester side of the instruction-memory interface: owns the PC, drives the memory enable and address, absorbs miss wait-states, and delivers instruction/PC pairs to decode over a valid/ready handshake.
- Sits between the instruction ROM (combinational read, miss flag) and the decode stage.
- Handles branch redirects and downstream backpressure, and keeps a saturating miss counter for performance monitoring.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] are ignored and treated as 0.
- MISS_CNT_W, 16, width of the saturating miss counter.

Ports:
- Clk  in  1  single clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- IMem_En  out  1  memory read enable.
- IMem_Addr  out  32  word-aligned fetch address.
- IMem_Data  in  32  instruction word; valid in the same cycle as the address when IMem_Miss=0.
- IMem_Miss  in  1  1 = data not valid this cycle; hold the request.
- Br_Taken  in  1  redirect request, single-cycle pulse.
- Br_Target  in  32  redirect address.
- Dec_Ready  in  1  decode accepts this cycle.
- Dec_Valid  out  1  Dec_Inst/Dec_PC hold a valid pair.
- Dec_Inst  out  32  registered instruction.
- Dec_PC  out  32  address of Dec_Inst.
- Misalign  out  1  one-cycle pulse when Br_Target[1:0] != 0.
- Miss_Count  out  MISS_CNT_W  count of miss cycles, saturating.

Behaviour:
- Reset (Rst=0, asynchronous):
  - state=IDLE, PC=RESET_PC&~3.
  - IMem_En=0, IMem_Addr=PC.
  - Dec_Valid=0, Dec_Inst=0, Dec_PC=0, Misalign=0, Miss_Count=0.
  - Reset asserted mid-miss or mid-hold aborts immediately; no partial state survives.
- IMem_Addr is always equal to PC (registered). IMem_En=1 only in FETCH and MISS.
- Slot free: slot_free = !Dec_Valid || Dec_Ready.
- States:
  - IDLE: one cycle after reset release, then go to FETCH. IMem_En=0.
  - FETCH:
    - If IMem_Miss=1: go to MISS.
    - Else if slot_free: capture Dec_Inst<=IMem_Data, Dec_PC<=PC, Dec_Valid<=1, PC<=PC+4, stay in FETCH. Throughput is 1 instruction per cycle.
    - Else: go to HOLD. PC is unchanged and the data is not captured.
  - MISS:
    - IMem_En=1 and the address is held.
    - When IMem_Miss=0: capture under the same rule as FETCH (to FETCH if captured, to HOLD if not).
  - HOLD:
    - IMem_En=0, nothing fetched.
    - When Dec_Ready=1: Dec_Valid<=0 and go to FETCH. The next fetch re-reads PC.
- Decode handshake:
  - The transfer occurs on a cycle with Dec_Valid && Dec_Ready.
  - If no new capture happens in the same cycle, Dec_Valid<=0.
  - Dec_Inst and Dec_PC are stable while Dec_Valid && !Dec_Ready.
- Branch (highest priority, any state except IDLE):
  - PC<=Br_Target&~3, Dec_Valid<=0 (flush), next state=FETCH.
  - Any in-flight miss is abandoned, and a same-cycle IMem_Data capture is discarded.
  - Misalign<=1 for one cycle if Br_Target[1:0]!=0, else 0.
  - A branch in IDLE is ignored.
- Wrap-around: PC 32'hFFFF_FFFC + 4 -> 32'h0000_0000, with no flag.
- Miss_Count:
  - Increments by 1 on every cycle with IMem_En=1 && IMem_Miss=1.
  - Holds at all-ones (no wrap).
  - Not cleared by branches.
- IMem_Miss is don't-care when IMem_En=0.

Test Plan:
- Sequential fetch: RESET_PC=0, Miss=0, Dec_Ready=1 -> IMem_En rises 1 cycle after reset release; Dec_PC = 0,4,8,12 on consecutive cycles with Dec_Valid=1 throughout.
- Miss wait: Miss=1 for 3 cycles at PC=0x10 -> IMem_Addr held at 0x10 for 4 cycles, Dec_Valid low in between, Dec_PC=0x10 once Miss drops, Miss_Count=3.
- Backpressure: Dec_Ready=0 for 2 cycles while holding PC 0x8 -> Dec_Inst/Dec_PC stable, IMem_En=0 in HOLD; after Ready the next Dec_PC is 0xC with no skipped or duplicated PC.
- Branch during miss: in MISS at 0x20, Br_Taken with target 0x100 -> the next IMem_Addr is 0x100, no instruction from 0x20 is delivered, Dec_Valid=0 for that cycle.
- Misaligned target and wrap: Br_Target=0xFFFF_FFFE -> Misalign pulses once, then Dec_PC=0xFFFF_FFFC followed by 0x0000_0000.
- Async reset mid-operation and counter saturation: Rst=0 asserted between clock edges in HOLD -> all outputs are at reset values before the next edge. Separately, force Miss_Count to 0xFFFE and apply 3 miss cycles -> reads 0xFFFF.
